// File: rtl/param_commit_scheduler.sv
// Generates the snapshot bank's new_frame load strobe. Parameter changes may commit only in
// vertical blanking, after the crossing pipe settles, and not while the renderer reads them.
module param_commit_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_DEFER     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             render_busy,
  input  logic             dirty_toggle_async,
  input  logic             force_commit,
  output logic             commit,
  output logic             pending,
  output logic [1:0]       deferred_frames,
  output logic [CNT_W-1:0] commit_count
);

  localparam int unsigned CntW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [1:0]  MaxDef = 2'(MAX_DEFER);

  typedef enum logic [1:0] {StIdle, StSettle, StWaitRender, StCommit} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              commit_q;
  logic [1:0]        defer_q;
  logic [CNT_W-1:0]  count_q;

  logic sync1_q, sync2_q, hist_q;
  logic dirty_q, force_q, vsync_q;

  logic dirty_edge, rise, fall, at_max;
  logic [1:0] defer_inc;

  assign dirty_edge = sync2_q ^ hist_q;
  assign rise       = vsync & ~vsync_q;
  assign fall       = ~vsync & vsync_q;
  assign at_max     = (defer_q >= MaxDef);
  assign defer_inc  = at_max ? defer_q : defer_q + 2'd1;

  // A new edge or force request in the commit cycle wins over the clear, so it is never lost.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      dirty_q <= 1'b0;
      force_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      sync1_q <= dirty_toggle_async;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      dirty_q <= dirty_edge | (dirty_q & ~commit_q);
      force_q <= force_commit | (force_q & ~commit_q);
      vsync_q <= vsync;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      defer_q  <= '0;
      count_q  <= '0;
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise && pending) begin
            state_q <= StSettle;
            cnt_q   <= CntW'(SETTLE_CYCLES - 1);
          end
        end
        StSettle: begin
          if (fall) begin
            state_q <= StIdle;
            defer_q <= defer_inc;
          end else if (cnt_q == '0) begin
            state_q <= StWaitRender;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StWaitRender: begin
          // Starvation bound: once the deferral limit is hit, busy no longer blocks the commit.
          if (!render_busy || at_max) begin
            state_q  <= StCommit;
            commit_q <= 1'b1;
          end else if (fall) begin
            state_q <= StIdle;
            defer_q <= defer_inc;
          end
        end
        StCommit: begin
          state_q <= StIdle;
          defer_q <= '0;
          count_q <= count_q + CNT_W'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign commit          = commit_q;
  assign pending         = dirty_q | force_q;
  assign deferred_frames = defer_q;
  assign commit_count    = count_q;

endmodule
